// File: rtl/serial_adder_controller.sv
// serial_adder_controller: bit-serial WIDTH-bit adder, one bit per clock, LSB first, registered carry.
// Latency: result valid and o_done pulses WIDTH edges after the accepting edge; one op per WIDTH+2 cycles.
// Backpressure: i_start is sampled only when idle (o_busy low); requests while busy are dropped, not queued.
//
// Ports:
//   i_clock, i_reset_n     rising-edge clock, asynchronous active-low reset
//   i_start                request, accepted only in IDLE
//   i_augend, i_addend     operands, latched on the accepting edge
//   i_subtract             (only with SERIAL_ADDER_SUBTRACT_EN) compute augend - addend
//   o_busy, o_done         busy in RUN/DONE; one-cycle done pulse in DONE
//   o_sum, o_carry         last completed result; o_carry=1 on subtract means no borrow
// Optional feature macro: SERIAL_ADDER_SUBTRACT_EN
module serial_adder_controller #(
    parameter int WIDTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_augend,
    input  logic [WIDTH-1:0] i_addend,
`ifdef SERIAL_ADDER_SUBTRACT_EN
    input  logic             i_subtract,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_o_sum;
    logic               r_o_carry;

    logic               w_accept;
    logic               w_last;
    logic               w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_sum_next;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_cin;

    // Single full-adder cell operating on the current LSBs.
    assign w_s        = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c        = (r_a[0] & r_b[0]) | ((r_a[0] ^ r_b[0]) & r_carry);
    // Sum shifts right so the first (LSB) bit ends up at bit 0 after WIDTH shifts.
    assign w_sum_next = {w_s, r_sum[WIDTH-1:1]};
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUBTRACT_EN
    // Two's complement subtract: invert addend and inject a carry-in of 1.
    assign w_b_load = i_subtract ? ~i_addend : i_addend;
    assign w_cin    = i_subtract;
`else
    assign w_b_load = i_addend;
    assign w_cin    = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                o_busy       = 1'b1;
                o_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_o_sum   <= '0;
            r_o_carry <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= i_augend;
                r_b     <= w_b_load;
                r_carry <= w_cin;
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_sum   <= w_sum_next;
                r_carry <= w_c;
                r_cnt   <= r_cnt + CNT_W'(1);
                // Publish on the final bit's edge so the result includes that bit.
                if (w_last) begin
                    r_o_sum   <= w_sum_next;
                    r_o_carry <= w_c;
                end
            end
        end
    end

    assign o_sum   = r_o_sum;
    assign o_carry = r_o_carry;

endmodule

// File: tb/tb_serial_adder_controller.sv
module tb_serial_adder_controller;

    localparam int WIDTH = 8;

    logic             i_clock;
    logic             i_reset_n;
    logic             i_start;
    logic [WIDTH-1:0] i_augend;
    logic [WIDTH-1:0] i_addend;
    logic             i_subtract;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;

    int checks   = 0;
    int failures = 0;

    serial_adder_controller #(.WIDTH(WIDTH)) dut (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_start    (i_start),
        .i_augend   (i_augend),
        .i_addend   (i_addend),
`ifdef SERIAL_ADDER_SUBTRACT_EN
        .i_subtract (i_subtract),
`endif
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_sum      (o_sum),
        .o_carry    (o_carry)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [7:0] augend;
        logic [7:0] addend;
        logic       sub;
        logic [7:0] exp_sum;
        logic       exp_carry;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation from IDLE and check latency, held result during RUN,
    // final result, and that done/busy drop one edge after done.
    task automatic run_op(input vec_t v, input logic [7:0] prev_sum, input logic prev_carry);
        int n;
        @(negedge i_clock);
        i_start    = 1'b1;
        i_augend   = v.augend;
        i_addend   = v.addend;
        i_subtract = v.sub;
        @(posedge i_clock);
        #1;
        i_start  = 1'b0;
        i_augend = 8'hC3;
        i_addend = 8'h3C;
        check("busy_after_accept", {31'd0, o_busy}, 32'd1);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge i_clock);
            #1;
            n++;
            if (o_done) break;
            check("sum_held_in_run", {24'd0, o_sum}, {24'd0, prev_sum});
            check("carry_held_in_run", {31'd0, o_carry}, {31'd0, prev_carry});
        end
        check("latency_edges", n, WIDTH);
        check("sum", {24'd0, o_sum}, {24'd0, v.exp_sum});
        check("carry", {31'd0, o_carry}, {31'd0, v.exp_carry});
        @(posedge i_clock);
        #1;
        check("done_one_cycle", {31'd0, o_done}, 32'd0);
        check("busy_low_after_done", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        vec_t       vecs[$];
        logic [7:0] prev_sum;
        logic       prev_carry;
        int         done_cnt;
        int         done_at[$];
        logic       prev_done;

        i_reset_n  = 1'b0;
        i_start    = 1'b0;
        i_augend   = '0;
        i_addend   = '0;
        i_subtract = 1'b0;

        vecs.push_back('{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
`ifdef SERIAL_ADDER_SUBTRACT_EN
        vecs.push_back('{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1});
        vecs.push_back('{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0});
        vecs.push_back('{8'h33, 8'h33, 1'b1, 8'h00, 1'b1});
`endif

        // Reset state
        #12;
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_sum", {24'd0, o_sum}, 32'd0);
        check("rst_carry", {31'd0, o_carry}, 32'd0);
        @(negedge i_clock);
        i_reset_n = 1'b1;

        // Table-driven operations, each checking the previous result is held in RUN
        prev_sum   = 8'h00;
        prev_carry = 1'b0;
        foreach (vecs[i]) begin
            run_op(vecs[i], prev_sum, prev_carry);
            prev_sum   = vecs[i].exp_sum;
            prev_carry = vecs[i].exp_carry;
        end

        // Start held high: one op per WIDTH+2 edges, operands scrambled while busy
        @(negedge i_clock);
        i_start    = 1'b1;
        i_subtract = 1'b0;
        prev_done  = 1'b0;
        for (int t = 1; t <= 32; t++) begin
            i_augend = o_busy ? 8'hFF : 8'h01;
            i_addend = o_busy ? 8'hFF : 8'h01;
            @(posedge i_clock);
            #1;
            if (o_done) begin
                done_at.push_back(t);
                check("held_sum", {24'd0, o_sum}, 32'h02);
                check("held_carry", {31'd0, o_carry}, 32'd0);
                check("held_done_width", {31'd0, prev_done}, 32'd0);
            end
            prev_done = o_done;
            @(negedge i_clock);
        end
        i_start = 1'b0;
        check("held_done_count", done_at.size(), 3);
        if (done_at.size() == 3) begin
            check("held_first_done", done_at[0], WIDTH + 1);
            check("held_gap0", done_at[1] - done_at[0], WIDTH + 2);
            check("held_gap1", done_at[2] - done_at[1], WIDTH + 2);
        end
        repeat (3) @(posedge i_clock);

        // Async reset in the middle of RUN
        @(negedge i_clock);
        i_start  = 1'b1;
        i_augend = 8'h5A;
        i_addend = 8'h3C;
        @(posedge i_clock);
        #1;
        i_start = 1'b0;
        repeat (4) @(posedge i_clock);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_sum", {24'd0, o_sum}, 32'd0);
        check("mid_rst_carry", {31'd0, o_carry}, 32'd0);
        @(negedge i_clock);
        i_reset_n = 1'b1;
        done_cnt = 0;
        for (int t = 0; t < 12; t++) begin
            @(posedge i_clock);
            #1;
            if (o_done) done_cnt++;
        end
        check("mid_rst_no_done", done_cnt, 0);
        run_op('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1}, 8'h00, 1'b0);

        // Start pulses during RUN and during DONE are dropped
        @(negedge i_clock);
        i_start  = 1'b1;
        i_augend = 8'h5A;
        i_addend = 8'h3C;
        @(posedge i_clock);
        #1;
        i_start  = 1'b0;
        i_augend = 8'hFF;
        i_addend = 8'hFF;
        done_cnt = 0;
        for (int t = 1; t <= 25; t++) begin
            @(negedge i_clock);
            i_start = (t == 3) || o_done;
            @(posedge i_clock);
            #1;
            if (o_done) done_cnt++;
        end
        i_start = 1'b0;
        check("ignore_done_count", done_cnt, 1);
        check("ignore_sum", {24'd0, o_sum}, 32'h96);
        check("ignore_carry", {31'd0, o_carry}, 32'd0);
        check("ignore_busy", {31'd0, o_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
        $fatal(1);
    end

endmodule
